auc_dispatch: RTL and testbench
===============================

// Module: auc_dispatch
// PURPOSE
//   Parametrised controller front-end for the arithmetic-unit cluster. Accepts one command at a
//   time (valid/ready), gives the RAM write port to the host loader for a preload window, then
//   starts exactly one of NENG engines (rand, inversion, mmul, ...). For the active engine it
//   muxes that engine's RAM, AU start, opcode and carry lines, captures the result, and reports
//   DONE/ERROR. A watchdog turns a hung engine into ERROR instead of a stall.
// PARAMETERS
//   WIDTH     256  datapath / RAM word width
//   ADDR      5    RAM address width
//   NENG      4    number of engines (>=2)
//   MW        3    cmd_mode width; mode value = engine index
//   START_DLY 3    au_start delay in cycles, aligns with RAM read latency (>=1)
//   PRELOAD   2    loader-owned RAM write cycles after accept (0 = no preload window)
//   TMO_W     16   watchdog width; timeout after 2**TMO_W-1 RUN cycles
// PORTS
//   clk        in   1            clock
//   rst        in   1            asynchronous reset, active-low
//   cmd_vld    in   1            command valid
//   cmd_rdy    out  1            ready; high only in IDLE
//   cmd_mode   in   MW           engine select
//   eng_en     out  NENG         one-hot, 1-cycle start pulse to the selected engine
//   eng_done   in   NENG         per-engine completion pulse
//   eng_radd   in   NENG*ADDR    per-engine RAM read address (engine i at [i*ADDR +: ADDR])
//   eng_wen    in   NENG         per-engine RAM write enable
//   eng_wadd   in   NENG*ADDR    per-engine RAM write address
//   eng_wdat   in   NENG*WIDTH   per-engine RAM write data
//   eng_austart in  NENG         per-engine AU start request
//   eng_auop   in   NENG*4       per-engine AU opcode
//   eng_carry  in   NENG         per-engine AU carry-in
//   ld_wen / ld_wadd / ld_wdat  in  1/ADDR/WIDTH  host loader RAM write port
//   ram_radd / ram_wen / ram_wadd / ram_wdat  out  ADDR/1/ADDR/WIDTH  shared RAM ports
//   au_start   out  1            delayed AU start
//   au_opcode  out  4            AU opcode of the selected engine
//   au_carry   out  1            AU carry of the selected engine
//   rslt       out  WIDTH        last captured result
//   status     out  2            00 IDLE, 01 CAL, 10 DONE (1 cycle), 11 ERROR (1 cycle)
//   busy       out  1            high in LOAD and RUN
// BEHAVIOUR
//   Reset, asynchronous: state IDLE; sel=0; eng_en=0; rslt=0; status=00; busy=0;
//     au_start pipe cleared; watchdog=0. Reset during LOAD/RUN aborts with no DONE or ERROR.
//   FSM IDLE->LOAD->RUN->IDLE. The command is accepted on cmd_vld&cmd_rdy and sel<=cmd_mode.
//     cmd_mode>=NENG: no eng_en, status=11 next cycle, stay IDLE, rslt unchanged.
//     Valid mode: LOAD for PRELOAD cycles. PRELOAD=0 goes straight to RUN.
//     The first RUN cycle asserts eng_en[sel] for 1 cycle. Accept at cycle 0 gives
//     eng_en at cycle PRELOAD+1.
//   RAM mux: in LOAD, ram_wen/wadd/wdat = ld_*. In RUN, they come from engine sel.
//     In IDLE, ram_wen=0. ram_radd = eng_radd[sel] in all states. Outputs are combinational.
//   au_opcode and au_carry come combinationally from engine sel. au_start = eng_austart[sel]
//     gated by RUN and delayed START_DLY registers. The pipe is flushed on leaving RUN.
//   Completion: eng_done[sel] in RUN, including the eng_en cycle, captures rslt<=eng_wdat[sel].
//     Next cycle: status=10 and state IDLE.
//     eng_done of a non-selected engine is ignored at all times.
//   Watchdog: counts RUN cycles and resets on entering RUN. At all-ones with no done:
//     status=11, state IDLE, rslt unchanged. A done in the terminal cycle wins (DONE).
//   status=01 throughout LOAD/RUN, except the 1-cycle DONE/ERROR codes; otherwise 00.
//     status and busy are registered.
//   cmd_rdy=0 outside IDLE. A cmd_vld held during an operation is accepted on the first IDLE
//     cycle after DONE/ERROR, giving back-to-back operation.
// TESTING
//   mode=1, PRELOAD=2: ld_wen writes at cycles 1-2 reach RAM; eng_en=4'b0010 at cycle 3.
//   Engine 1 raises done with wdat=0xABCD -> rslt=0xABCD, status=10 for exactly 1 cycle.
//   eng_austart[2] pulse in RUN (mode=2) -> au_start pulse exactly 3 cycles later;
//     au_opcode tracks eng_auop[2].
//   cmd_mode=5 with NENG=4 -> status=11 next cycle; eng_en stays 0; cmd_rdy stays high.
//   TMO_W=4, engine never done -> status=11 after 15 RUN cycles; returns IDLE; rslt unchanged.
//   eng_done[0] while sel=3 -> ignored. rst low mid-RUN -> all outputs 0 immediately;
//     no status pulse after rst is released.
//   cmd_vld held across two operations -> second eng_en in the cycle after DONE + PRELOAD + 1.

Source files
------------

// File: rtl/auc_dispatch.sv
// rtl/auc_dispatch.sv - arithmetic-unit cluster command dispatcher
//
// Takes one command at a time. A valid command first hands the RAM write
// port to the host loader for PRELOAD cycles, then pulses the chosen engine's
// start line and routes that engine's RAM, AU start/opcode/carry lines to the
// shared resources until it signals done or the watchdog expires.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmd_vld_i/cmd_rdy_o/cmd_mode_i command handshake and engine select
//   eng_en_o                      one-hot, single-cycle engine start
//   eng_done_i, eng_radd_i, eng_wen_i, eng_wadd_i, eng_wdat_i,
//   eng_austart_i, eng_auop_i, eng_carry_i   per-engine request buses
//   ld_wen_i/ld_wadd_i/ld_wdat_i  host loader RAM write port
//   ram_radd_o/ram_wen_o/ram_wadd_o/ram_wdat_o  shared RAM ports
//   au_start_o/au_opcode_o/au_carry_o           shared AU control
//   rslt_o                        last captured result
//   status_o                      00 idle, 01 cal, 10 done, 11 error
//   busy_o                        high while loading or running
module auc_dispatch #(
    parameter int WIDTH     = 256,
    parameter int ADDR      = 5,
    parameter int NENG      = 4,
    parameter int MW        = 3,
    parameter int START_DLY = 3,
    parameter int PRELOAD   = 2,
    parameter int TMO_W     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_vld_i,
    output logic                   cmd_rdy_o,
    input  logic [MW-1:0]          cmd_mode_i,
    output logic [NENG-1:0]        eng_en_o,
    input  logic [NENG-1:0]        eng_done_i,
    input  logic [NENG*ADDR-1:0]   eng_radd_i,
    input  logic [NENG-1:0]        eng_wen_i,
    input  logic [NENG*ADDR-1:0]   eng_wadd_i,
    input  logic [NENG*WIDTH-1:0]  eng_wdat_i,
    input  logic [NENG-1:0]        eng_austart_i,
    input  logic [NENG*4-1:0]      eng_auop_i,
    input  logic [NENG-1:0]        eng_carry_i,
    input  logic                   ld_wen_i,
    input  logic [ADDR-1:0]        ld_wadd_i,
    input  logic [WIDTH-1:0]       ld_wdat_i,
    output logic [ADDR-1:0]        ram_radd_o,
    output logic                   ram_wen_o,
    output logic [ADDR-1:0]        ram_wadd_o,
    output logic [WIDTH-1:0]       ram_wdat_o,
    output logic                   au_start_o,
    output logic [3:0]             au_opcode_o,
    output logic                   au_carry_o,
    output logic [WIDTH-1:0]       rslt_o,
    output logic [1:0]             status_o,
    output logic                   busy_o
);

    localparam int LW = (PRELOAD > 1) ? $clog2(PRELOAD) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CAL  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t                 state_q;
    logic [MW-1:0]          sel_q;
    logic [LW-1:0]          ld_cnt_q;
    logic [TMO_W-1:0]       wd_q;
    logic [NENG-1:0]        eng_en_q;
    logic [WIDTH-1:0]       rslt_q;
    logic [1:0]             status_q;
    logic                   busy_q;
    logic [START_DLY-1:0]   start_pipe_q;

    logic                   mode_ok;
    logic                   sel_done;
    logic                   sel_wen;
    logic                   sel_austart;
    logic                   sel_carry;
    logic [ADDR-1:0]        sel_radd;
    logic [ADDR-1:0]        sel_wadd;
    logic [WIDTH-1:0]       sel_wdat;
    logic [3:0]             sel_auop;
    logic                   run_hold;

    assign mode_ok = (int'(cmd_mode_i) < NENG);

    // Selected-engine view. An out-of-range sel (left by a rejected command)
    // selects nothing, so every routed line reads as zero.
    always_comb begin
        sel_done    = 1'b0;
        sel_wen     = 1'b0;
        sel_austart = 1'b0;
        sel_carry   = 1'b0;
        sel_radd    = '0;
        sel_wadd    = '0;
        sel_wdat    = '0;
        sel_auop    = '0;
        for (int i = 0; i < NENG; i++) begin
            if (int'(sel_q) == i) begin
                sel_done    = eng_done_i[i];
                sel_wen     = eng_wen_i[i];
                sel_austart = eng_austart_i[i];
                sel_carry   = eng_carry_i[i];
                sel_radd    = eng_radd_i[i*ADDR +: ADDR];
                sel_wadd    = eng_wadd_i[i*ADDR +: ADDR];
                sel_wdat    = eng_wdat_i[i*WIDTH +: WIDTH];
                sel_auop    = eng_auop_i[i*4 +: 4];
            end
        end
    end

    // RUN continues into the next cycle: neither completion nor timeout now.
    assign run_hold = (state_q == S_RUN) && !sel_done && !(&wd_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            ld_cnt_q <= '0;
            wd_q     <= '0;
            eng_en_q <= '0;
            rslt_q   <= '0;
            status_q <= ST_IDLE;
            busy_q   <= 1'b0;
        end else begin
            eng_en_q <= '0;
            case (state_q)
                S_IDLE: begin
                    status_q <= ST_IDLE;
                    busy_q   <= 1'b0;
                    if (cmd_vld_i) begin
                        sel_q <= cmd_mode_i;
                        if (!mode_ok) begin
                            status_q <= ST_ERR;
                        end else if (PRELOAD == 0) begin
                            state_q  <= S_RUN;
                            eng_en_q <= NENG'(1) << cmd_mode_i;
                            wd_q     <= TMO_W'(1);
                            status_q <= ST_CAL;
                            busy_q   <= 1'b1;
                        end else begin
                            state_q  <= S_LOAD;
                            ld_cnt_q <= LW'(PRELOAD - 1);
                            status_q <= ST_CAL;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (ld_cnt_q == '0) begin
                        state_q  <= S_RUN;
                        eng_en_q <= NENG'(1) << sel_q;
                        // wd_q counts RUN cycles including the current one.
                        wd_q     <= TMO_W'(1);
                    end else begin
                        ld_cnt_q <= ld_cnt_q - LW'(1);
                    end
                end
                S_RUN: begin
                    if (sel_done) begin
                        // Done takes priority over a simultaneous timeout.
                        rslt_q   <= sel_wdat;
                        status_q <= ST_DONE;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                        wd_q     <= '0;
                    end else if (&wd_q) begin
                        status_q <= ST_ERR;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                        wd_q     <= '0;
                    end else begin
                        wd_q <= wd_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    status_q <= ST_IDLE;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // AU start delay line; shifts only while RUN carries on, so nothing from
    // a finished operation can leak out after it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_pipe_q <= '0;
        end else if (run_hold) begin
            start_pipe_q <= START_DLY'({start_pipe_q, sel_austart});
        end else begin
            start_pipe_q <= '0;
        end
    end

    always_comb begin
        ram_radd_o = sel_radd;
        ram_wen_o  = 1'b0;
        ram_wadd_o = '0;
        ram_wdat_o = '0;
        case (state_q)
            S_LOAD: begin
                ram_wen_o  = ld_wen_i;
                ram_wadd_o = ld_wadd_i;
                ram_wdat_o = ld_wdat_i;
            end
            S_RUN: begin
                ram_wen_o  = sel_wen;
                ram_wadd_o = sel_wadd;
                ram_wdat_o = sel_wdat;
            end
            default: begin
                ram_wen_o = 1'b0;
            end
        endcase
    end

    assign cmd_rdy_o   = (state_q == S_IDLE);
    assign eng_en_o    = eng_en_q;
    assign au_start_o  = start_pipe_q[START_DLY-1];
    assign au_opcode_o = sel_auop;
    assign au_carry_o  = sel_carry;
    assign rslt_o      = rslt_q;
    assign status_o    = status_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_auc_dispatch.sv
// tb/tb_auc_dispatch.sv - self-checking bench for auc_dispatch
module tb_auc_dispatch;

    localparam int W  = 256;
    localparam int A  = 5;
    localparam int N  = 4;
    localparam int PL = 2;
    localparam int TW = 4;
    localparam int RUN_MAX = (1 << TW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_vld;
    logic            cmd_rdy;
    logic [2:0]      cmd_mode;
    logic [N-1:0]    eng_en;
    logic [N-1:0]    eng_done;
    logic [N*A-1:0]  eng_radd;
    logic [N-1:0]    eng_wen;
    logic [N*A-1:0]  eng_wadd;
    logic [N*W-1:0]  eng_wdat;
    logic [N-1:0]    eng_austart;
    logic [N*4-1:0]  eng_auop;
    logic [N-1:0]    eng_carry;
    logic            ld_wen;
    logic [A-1:0]    ld_wadd;
    logic [W-1:0]    ld_wdat;
    logic [A-1:0]    ram_radd;
    logic            ram_wen;
    logic [A-1:0]    ram_wadd;
    logic [W-1:0]    ram_wdat;
    logic            au_start;
    logic [3:0]      au_opcode;
    logic            au_carry;
    logic [W-1:0]    rslt;
    logic [1:0]      status;
    logic            busy;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] m_rslt;

    always #5 clk = ~clk;

    auc_dispatch #(
        .WIDTH(W), .ADDR(A), .NENG(N), .MW(3), .START_DLY(3), .PRELOAD(PL), .TMO_W(TW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy), .cmd_mode_i(cmd_mode),
        .eng_en_o(eng_en), .eng_done_i(eng_done), .eng_radd_i(eng_radd),
        .eng_wen_i(eng_wen), .eng_wadd_i(eng_wadd), .eng_wdat_i(eng_wdat),
        .eng_austart_i(eng_austart), .eng_auop_i(eng_auop), .eng_carry_i(eng_carry),
        .ld_wen_i(ld_wen), .ld_wadd_i(ld_wadd), .ld_wdat_i(ld_wdat),
        .ram_radd_o(ram_radd), .ram_wen_o(ram_wen), .ram_wadd_o(ram_wadd),
        .ram_wdat_o(ram_wdat), .au_start_o(au_start), .au_opcode_o(au_opcode),
        .au_carry_o(au_carry), .rslt_o(rslt), .status_o(status), .busy_o(busy)
    );

    function automatic logic [W-1:0] rnd256();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic rand_inputs();
        eng_radd    = 20'($urandom);
        eng_wen     = 4'($urandom);
        eng_wadd    = 20'($urandom);
        for (int i = 0; i < N; i++) eng_wdat[i*W +: W] = rnd256();
        eng_auop    = 16'($urandom);
        eng_carry   = 4'($urandom);
        eng_austart = '0;
        ld_wen      = 1'($urandom);
        ld_wadd     = 5'($urandom);
        ld_wdat     = rnd256();
    endtask

    task automatic cycle_start();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_vld = 1'b0; cmd_mode = '0; eng_done = '0;
        rand_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (eng_en !== 4'b0) begin miscompares++; $display("FAIL reset_eng_en got %b exp 0000", eng_en); end
        vectors++; if (status !== 2'b00) begin miscompares++; $display("FAIL reset_status got %b exp 00", status); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (rslt !== '0) begin miscompares++; $display("FAIL reset_rslt got %h exp 0", rslt); end
        vectors++; if (au_start !== 1'b0) begin miscompares++; $display("FAIL reset_au_start got %b exp 0", au_start); end
        vectors++; if (ram_wen !== 1'b0) begin miscompares++; $display("FAIL reset_ram_wen got %b exp 0", ram_wen); end
        vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_rdy got %b exp 1", cmd_rdy); end
        m_rslt = '0;
        cycle_start();
        rst_n = 1'b1;
        cycle_start();
    endtask

    // One operation accepted at cycle 0. k = RUN cycle (1-based) in which the
    // engine signals done; k = 0 means it never does and the watchdog fires.
    task automatic test_op(input int mode, input int k, input bit use_fixed, input logic [W-1:0] fixed);
        int done_c, last;
        logic [W-1:0] cap;
        logic [1:0]   exp_st;
        logic [N-1:0] exp_en;
        logic         exp_wen;
        cap    = '0;
        done_c = (k == 0) ? -1 : PL + k;
        last   = (k == 0) ? PL + 1 + RUN_MAX : PL + 1 + k;
        for (int c = 0; c <= last + 1; c++) begin
            cycle_start();
            rand_inputs();
            cmd_vld  = (c == 0);
            cmd_mode = 3'(mode);
            eng_done = ~(4'(1) << mode);
            if (c == done_c) begin
                eng_done[mode] = 1'b1;
                if (use_fixed) eng_wdat[mode*W +: W] = fixed;
                cap = eng_wdat[mode*W +: W];
            end
            @(negedge clk);
            exp_st = (c == 0) ? 2'b00 : (c < last) ? 2'b01 :
                     (c == last) ? ((k == 0) ? 2'b11 : 2'b10) : 2'b00;
            exp_en = (c == PL + 1) ? (4'(1) << mode) : 4'b0;
            exp_wen = (c >= 1 && c <= PL) ? ld_wen :
                      (c > PL && c < last) ? eng_wen[mode] : 1'b0;
            vectors++; if (status !== exp_st) begin miscompares++; $display("FAIL op_status c=%0d got %b exp %b", c, status, exp_st); end
            vectors++; if (busy !== (c >= 1 && c < last)) begin miscompares++; $display("FAIL op_busy c=%0d got %b", c, busy); end
            vectors++; if (eng_en !== exp_en) begin miscompares++; $display("FAIL op_eng_en c=%0d got %b exp %b", c, eng_en, exp_en); end
            vectors++; if (cmd_rdy !== (c == 0 || c >= last)) begin miscompares++; $display("FAIL op_cmd_rdy c=%0d got %b", c, cmd_rdy); end
            vectors++; if (ram_wen !== exp_wen) begin miscompares++; $display("FAIL op_ram_wen c=%0d got %b exp %b", c, ram_wen, exp_wen); end
            if (c >= 1 && c <= PL) begin
                vectors++; if (ram_wadd !== ld_wadd || ram_wdat !== ld_wdat) begin miscompares++; $display("FAIL op_load_port c=%0d got %h exp %h", c, ram_wadd, ld_wadd); end
            end
            if (c > PL && c < last) begin
                vectors++; if (ram_wadd !== eng_wadd[mode*A +: A] || ram_wdat !== eng_wdat[mode*W +: W]) begin miscompares++; $display("FAIL op_eng_port c=%0d got %h exp %h", c, ram_wadd, eng_wadd[mode*A +: A]); end
            end
            if (c >= 1) begin
                vectors++; if (ram_radd !== eng_radd[mode*A +: A]) begin miscompares++; $display("FAIL op_radd c=%0d got %h exp %h", c, ram_radd, eng_radd[mode*A +: A]); end
                vectors++; if (au_opcode !== eng_auop[mode*4 +: 4] || au_carry !== eng_carry[mode]) begin miscompares++; $display("FAIL op_au_ctrl c=%0d got %h/%b exp %h/%b", c, au_opcode, au_carry, eng_auop[mode*4 +: 4], eng_carry[mode]); end
            end
            if (c == last) begin
                if (k != 0) m_rslt = cap;
                vectors++; if (rslt !== m_rslt) begin miscompares++; $display("FAIL op_rslt got %h exp %h", rslt, m_rslt); end
            end
        end
        cmd_vld = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] v;
        v = 256'hABCD;
        test_op(1, 4, 1'b1, v);
    endtask

    task automatic test_bad_mode();
        int m;
        m = $urandom_range(4, 7);
        for (int c = 0; c <= 2; c++) begin
            cycle_start();
            rand_inputs();
            eng_done = '1;
            cmd_vld  = (c == 0);
            cmd_mode = 3'(m);
            @(negedge clk);
            vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL bad_cmd_rdy c=%0d got %b exp 1", c, cmd_rdy); end
            vectors++; if (eng_en !== 4'b0) begin miscompares++; $display("FAIL bad_eng_en c=%0d got %b exp 0000", c, eng_en); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bad_busy c=%0d got %b exp 0", c, busy); end
            vectors++; if (status !== ((c == 1) ? 2'b11 : 2'b00)) begin miscompares++; $display("FAIL bad_status c=%0d got %b", c, status); end
            vectors++; if (rslt !== m_rslt) begin miscompares++; $display("FAIL bad_rslt c=%0d got %h exp %h", c, rslt, m_rslt); end
        end
        cmd_vld = 1'b0;
    endtask

    task automatic test_austart();
        int last;
        last = PL + 1 + 10;
        for (int c = 0; c <= last; c++) begin
            cycle_start();
            rand_inputs();
            cmd_vld     = (c == 0);
            cmd_mode    = 3'd2;
            eng_austart = 4'($urandom) & 4'b1011;
            if (c == 1 || c == 5) eng_austart[2] = 1'b1;
            eng_done    = 4'b1011;
            if (c == last - 1) begin
                eng_done[2] = 1'b1;
                m_rslt = eng_wdat[2*W +: W];
            end
            @(negedge clk);
            vectors++; if (au_start !== (c == 8)) begin miscompares++; $display("FAIL au_start c=%0d got %b exp %b", c, au_start, (c == 8)); end
            if (c >= 1) begin
                vectors++; if (au_opcode !== eng_auop[8 +: 4]) begin miscompares++; $display("FAIL au_opcode c=%0d got %h exp %h", c, au_opcode, eng_auop[8 +: 4]); end
            end
            if (c == last) begin
                vectors++; if (status !== 2'b10 || rslt !== m_rslt) begin miscompares++; $display("FAIL au_done got %b/%h exp 10/%h", status, rslt, m_rslt); end
            end
        end
        cmd_vld = 1'b0;
    endtask

    task automatic test_timeout();
        logic [W-1:0] z;
        z = '0;
        test_op($urandom_range(0, 3), 0, 1'b0, z);
        test_op($urandom_range(0, 3), RUN_MAX, 1'b0, z);
    endtask

    task automatic test_random();
        logic [W-1:0] z;
        z = '0;
        for (int i = 0; i < 6; i++) test_op($urandom_range(0, 3), $urandom_range(1, RUN_MAX), 1'b0, z);
    endtask

    task automatic test_back_to_back();
        int ma, mb, k1, k2, d, fin;
        logic [N-1:0] exp_en;
        ma = $urandom_range(0, 3); mb = $urandom_range(0, 3);
        k1 = $urandom_range(1, 6); k2 = $urandom_range(1, 6);
        d   = PL + 1 + k1;
        fin = d + PL + 1 + k2;
        for (int c = 0; c <= fin + 1; c++) begin
            cycle_start();
            rand_inputs();
            cmd_vld  = (c <= d);
            cmd_mode = (c == 0) ? 3'(ma) : 3'(mb);
            eng_done = '0;
            if (c == d - 1) begin eng_done[ma] = 1'b1; m_rslt = eng_wdat[ma*W +: W]; end
            if (c == fin - 1) begin eng_done[mb] = 1'b1; m_rslt = eng_wdat[mb*W +: W]; end
            @(negedge clk);
            exp_en = (c == PL + 1) ? (4'(1) << ma) : (c == d + PL + 1) ? (4'(1) << mb) : 4'b0;
            vectors++; if (eng_en !== exp_en) begin miscompares++; $display("FAIL b2b_eng_en c=%0d got %b exp %b", c, eng_en, exp_en); end
            if (c == d || c == fin) begin
                vectors++; if (status !== 2'b10 || rslt !== m_rslt) begin miscompares++; $display("FAIL b2b_done c=%0d got %b/%h exp 10/%h", c, status, rslt, m_rslt); end
            end
            if (c == d + 1) begin
                vectors++; if (status !== 2'b01 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_reaccept got %b/%b exp 01/1", status, busy); end
            end
        end
        cmd_vld = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        for (int c = 0; c <= 5; c++) begin
            cycle_start();
            rand_inputs();
            cmd_vld  = (c == 0);
            cmd_mode = 3'd1;
            eng_done = '0;
            if (c == 3) eng_austart = 4'b0010;
            if (c == 5) begin
                rst_n = 1'b0;
                #1;
                vectors++; if (eng_en !== 4'b0 || status !== 2'b00 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ctrl got %b/%b/%b exp 0000/00/0", eng_en, status, busy); end
                vectors++; if (rslt !== '0 || au_start !== 1'b0) begin miscompares++; $display("FAIL rst_mid_data got %h/%b exp 0/0", rslt, au_start); end
            end
            @(negedge clk);
            if (c == 4) begin
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy got %b exp 1", busy); end
            end
        end
        m_rslt = '0;
        for (int c = 6; c <= 20; c++) begin
            cycle_start();
            rand_inputs();
            eng_done = '1;
            if (c == 8) rst_n = 1'b1;
            @(negedge clk);
            vectors++; if (status !== 2'b00 || busy !== 1'b0 || au_start !== 1'b0 || eng_en !== 4'b0) begin miscompares++; $display("FAIL rst_after c=%0d got st=%b busy=%b aus=%b en=%b", c, status, busy, au_start, eng_en); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout bench did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_bad_mode();
        test_austart();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
